// File: rtl/detect_event_counter.sv
// Counts accepted detection pulses with saturation, plus a fixed-length threshold alert.
// Single-cycle: count/sat/irq update at the edge that accepts the event; no backpressure.
module detect_event_counter #(
    parameter int CNT_W    = 8,
    parameter int IRQ_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             z,
    input  logic             clr,
    input  logic [CNT_W-1:0] thresh,
    output logic [CNT_W-1:0] count,
    output logic             irq,
    output logic             sat
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COUNT,
        ST_SAT
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [3:0]       HOLD_INIT = 4'(IRQ_HOLD);

    state_t           state_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             sat_q;
    logic             irq_q;
    logic [3:0]       hold_q;
    logic             accept;
    logic             hit;

    // In COUNT the counter is always below CNT_MAX, so the increment never wraps.
    assign accept  = (state_q == ST_COUNT) && en && z && !clr;
    assign count_d = count_q + CNT_W'(1);
    assign hit     = accept && (thresh != '0) && (count_d == thresh);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            sat_q   <= 1'b0;
            irq_q   <= 1'b0;
            hold_q  <= '0;
        end else if (clr) begin
            state_q <= en ? ST_COUNT : ST_IDLE;
            count_q <= '0;
            sat_q   <= 1'b0;
            irq_q   <= 1'b0;
            hold_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (en) state_q <= ST_COUNT;
                end
                ST_COUNT: begin
                    if (!en)
                        state_q <= ST_IDLE;
                    else if (accept && (count_d == CNT_MAX))
                        state_q <= ST_SAT;
                end
                default: begin
                    state_q <= ST_SAT;
                end
            endcase

            if (accept) begin
                count_q <= count_d;
                if (count_d == CNT_MAX) sat_q <= 1'b1;
            end

            // A new hit restarts the hold window; otherwise the window runs down regardless of state.
            if (hit) begin
                hold_q <= HOLD_INIT;
                irq_q  <= 1'b1;
            end else if (hold_q != '0) begin
                hold_q <= hold_q - 4'd1;
                irq_q  <= (hold_q != 4'd1);
            end
        end
    end

    assign count = count_q;
    assign irq   = irq_q;
    assign sat   = sat_q;

endmodule
